tblock_dispatcher: RTL and testbench
====================================

TBLOCK_DISPATCHER -- requirements
Module: tblock_dispatcher

Interface
REQ-001 SHALL have parameter PcWidth, default 32, program counter width.
REQ-002 SHALL have parameter AddressWidth, default 32, data/parameter address width.
REQ-003 SHALL have parameter TblockIdxBits, default 4, thread-block index width.
REQ-004 SHALL have parameter TgroupIdBits, default 4, thread-group id width.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: launch_valid_i in 1; launch_ready_o out 1; launch_pc_i in PcWidth; launch_dp_addr_i in AddressWidth; launch_num_tblocks_i in TblockIdxBits+1 (block count); launch_tgroup_id_i in TgroupIdBits.
REQ-007 SHALL have ports: warp_free_i in 1; allocate_warp_o out 1; allocate_pc_o out PcWidth; allocate_dp_addr_o out AddressWidth; allocate_tblock_idx_o out TblockIdxBits; allocate_tgroup_id_o out TgroupIdBits.
REQ-008 SHALL have ports: tblock_done_i in 1; tblock_done_id_i in TgroupIdBits; tblock_done_ready_o out 1.
REQ-009 SHALL have ports: group_done_o out 1; group_done_id_o out TgroupIdBits; group_done_ready_i in 1.

Function
REQ-010 SHALL implement FSM states IDLE, DISPATCH, WAIT_DONE, REPORT.
REQ-011 SHALL assert launch_ready_o only in IDLE; on launch handshake, register pc, dp_addr, num_tblocks, tgroup_id, clear dispatched/completed counters, go to DISPATCH (or REPORT if num_tblocks==0).
REQ-012 SHALL assert allocate_warp_o in DISPATCH iff warp_free_i; allocation is accepted same cycle, no back-pressure beyond warp_free_i.
REQ-013 SHALL drive allocate_tblock_idx_o = dispatched counter, allocate_pc_o/dp_addr_o/tgroup_id_o = registered launch values; all zero outside DISPATCH.
REQ-014 SHALL increment dispatched counter per accepted allocation; after the allocation with index num_tblocks-1, go to WAIT_DONE next cycle (max num_tblocks = 2^TblockIdxBits, counter TblockIdxBits+1 wide, no wrap).
REQ-015 SHALL assert tblock_done_ready_o in DISPATCH and WAIT_DONE; count completion when tblock_done_i && tblock_done_ready_o && tblock_done_id_i == registered tgroup_id.
REQ-016 SHALL accept and drop (ready high, no count) a done with mismatched id; flag via assertion.
REQ-017 SHALL count allocation and completion in the same cycle independently.
REQ-018 SHALL enter REPORT when completed == num_tblocks and dispatched == num_tblocks, one cycle after the last completion.
REQ-019 SHALL, in REPORT, hold group_done_o=1, group_done_id_o=tgroup_id; on group_done_ready_i go to IDLE; group_done_id_o zero elsewhere.
REQ-020 SHALL keep tblock_done_ready_o low in IDLE and REPORT.
REQ-021 SHALL never let completed exceed dispatched (assertion).

Reset
REQ-022 SHALL on rst_ni low enter IDLE, clear all counters/registers; outputs: launch_ready_o=1, all others 0.
REQ-023 SHALL abandon any in-progress group on mid-operation reset with no group_done emitted.

Configuration
REQ-024 SHALL, with BGPU_DISPATCH_STALL_CNT_EN defined, add output stall_cycles_o (32 bit), reset 0, incrementing each DISPATCH cycle with warp_free_i low, saturating at all-ones, cleared on launch handshake.
REQ-025 SHALL, without BGPU_DISPATCH_STALL_CNT_EN, omit stall_cycles_o and its counter; all other behaviour identical.

Structure
REQ-026 SHALL place the FSM state enum in the shared package bgpu_pkg; widths stay module parameters.
REQ-027 SHALL be a single module, no sub-module; registers via the common FF macros.

Verification
REQ-028 Launch num=3, id=5, pc=0x100, warp_free_i=1 -> allocations idx 0,1,2 on 3 consecutive cycles, then WAIT_DONE; 3 dones id=5 -> group_done_o with id 5.
REQ-029 Launch num=4, warp_free_i toggling 1,0,0,1,1,1 -> exactly 4 allocations idx 0..3 in free cycles; stall_cycles_o=2 when macro defined.
REQ-030 Launch num=0, id=2 -> no allocate_warp_o, group_done_o=1 id 2 on second cycle after launch.
REQ-031 Launch num=2; done id=5 coincident with allocation idx 1 -> both counted; done id=7 -> dropped, no group_done.
REQ-032 group_done_ready_i held low 5 cycles -> group_done_o stable, launch_ready_o low; release -> IDLE, launch_ready_o=1 next cycle.
REQ-033 Reset asserted in DISPATCH after 1 of 4 allocations -> IDLE, all outputs zero, launch_ready_o=1, no group_done.

Source files
------------

// File: rtl/bgpu_pkg.sv
// Shared GPU block definitions: thread-block dispatcher FSM states.
package bgpu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISPATCH  = 2'd1,
        WAIT_DONE = 2'd2,
        REPORT    = 2'd3
    } tblock_disp_state_e;

endpackage

// File: rtl/tblock_dispatcher.sv
// Thread-block dispatcher: takes one launch, hands out its blocks to free warps, tracks completions.
// Optional stall-cycle counter output enabled by defining BGPU_DISPATCH_STALL_CNT_EN.

`ifndef BGPU_FF
`define BGPU_FF(q, d, rst_val) \
    always_ff @(posedge clk_i or negedge rst_ni) begin \
        if (!rst_ni) q <= (rst_val); \
        else         q <= (d); \
    end
`endif

module tblock_dispatcher
    import bgpu_pkg::*;
#(
    parameter int unsigned PcWidth       = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TblockIdxBits = 4,
    parameter int unsigned TgroupIdBits  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      launch_valid_i,
    output logic                      launch_ready_o,
    input  logic [PcWidth-1:0]        launch_pc_i,
    input  logic [AddressWidth-1:0]   launch_dp_addr_i,
    input  logic [TblockIdxBits:0]    launch_num_tblocks_i,
    input  logic [TgroupIdBits-1:0]   launch_tgroup_id_i,

    input  logic                      warp_free_i,
    output logic                      allocate_warp_o,
    output logic [PcWidth-1:0]        allocate_pc_o,
    output logic [AddressWidth-1:0]   allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0]  allocate_tblock_idx_o,
    output logic [TgroupIdBits-1:0]   allocate_tgroup_id_o,

    input  logic                      tblock_done_i,
    input  logic [TgroupIdBits-1:0]   tblock_done_id_i,
    output logic                      tblock_done_ready_o,

    output logic                      group_done_o,
    output logic [TgroupIdBits-1:0]   group_done_id_o,
    input  logic                      group_done_ready_i
`ifdef BGPU_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles_o
`endif
);

    localparam int unsigned CntW = TblockIdxBits + 1;

    tblock_disp_state_e        state_q, state_d;
    logic [PcWidth-1:0]        pc_q, pc_d;
    logic [AddressWidth-1:0]   dp_q, dp_d;
    logic [CntW-1:0]           num_q, num_d;
    logic [TgroupIdBits-1:0]   id_q, id_d;
    logic [CntW-1:0]           disp_q, disp_d;
    logic [CntW-1:0]           comp_q, comp_d;

    logic launch_fire, alloc_fire, done_ready, done_fire, done_drop;

    always_comb begin
        launch_fire = launch_valid_i && (state_q == IDLE);
        alloc_fire  = (state_q == DISPATCH) && warp_free_i;
        done_ready  = (state_q == DISPATCH) || (state_q == WAIT_DONE);
        done_fire   = tblock_done_i && done_ready && (tblock_done_id_i == id_q);
        // Stale or foreign completions are consumed so the sender never stalls.
        done_drop   = tblock_done_i && done_ready && (tblock_done_id_i != id_q);

        pc_d   = launch_fire ? launch_pc_i          : pc_q;
        dp_d   = launch_fire ? launch_dp_addr_i     : dp_q;
        num_d  = launch_fire ? launch_num_tblocks_i : num_q;
        id_d   = launch_fire ? launch_tgroup_id_i   : id_q;
        disp_d = launch_fire ? '0 : disp_q + CntW'(alloc_fire);
        comp_d = launch_fire ? '0 : comp_q + CntW'(done_fire);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (launch_fire)
                    state_d = (launch_num_tblocks_i == '0) ? REPORT : DISPATCH;
            DISPATCH:
                // A completion may land in the same cycle as the final allocation.
                if (disp_d == num_q)
                    state_d = (comp_d == num_q) ? REPORT : WAIT_DONE;
            WAIT_DONE:
                if (comp_d == num_q) state_d = REPORT;
            REPORT:
                if (group_done_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    `BGPU_FF(state_q, state_d, IDLE)
    `BGPU_FF(pc_q, pc_d, '0)
    `BGPU_FF(dp_q, dp_d, '0)
    `BGPU_FF(num_q, num_d, '0)
    `BGPU_FF(id_q, id_d, '0)
    `BGPU_FF(disp_q, disp_d, '0)
    `BGPU_FF(comp_q, comp_d, '0)

    always_comb begin
        launch_ready_o        = (state_q == IDLE);
        allocate_warp_o       = alloc_fire;
        allocate_pc_o         = '0;
        allocate_dp_addr_o    = '0;
        allocate_tblock_idx_o = '0;
        allocate_tgroup_id_o  = '0;
        if (state_q == DISPATCH) begin
            allocate_pc_o         = pc_q;
            allocate_dp_addr_o    = dp_q;
            allocate_tblock_idx_o = disp_q[TblockIdxBits-1:0];
            allocate_tgroup_id_o  = id_q;
        end
        tblock_done_ready_o = done_ready;
        group_done_o        = (state_q == REPORT);
        group_done_id_o     = (state_q == REPORT) ? id_q : '0;
    end

`ifdef BGPU_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (launch_fire)
            stall_d = '0;
        else if ((state_q == DISPATCH) && !warp_free_i && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    `BGPU_FF(stall_q, stall_d, '0)
    assign stall_cycles_o = stall_q;
`endif

`ifndef SYNTHESIS
    a_comp_le_disp: assert property (@(posedge clk_i) disable iff (!rst_ni) comp_q <= disp_q);
    c_done_id_drop: cover property (@(posedge clk_i) disable iff (!rst_ni) done_drop);
`endif

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Directed bench for tblock_dispatcher; stall counter checks compile in with BGPU_DISPATCH_STALL_CNT_EN.
module tb_tblock_dispatcher;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        launch_valid_i;
    logic        launch_ready_o;
    logic [31:0] launch_pc_i;
    logic [31:0] launch_dp_addr_i;
    logic [4:0]  launch_num_tblocks_i;
    logic [3:0]  launch_tgroup_id_i;
    logic        warp_free_i;
    logic        allocate_warp_o;
    logic [31:0] allocate_pc_o;
    logic [31:0] allocate_dp_addr_o;
    logic [3:0]  allocate_tblock_idx_o;
    logic [3:0]  allocate_tgroup_id_o;
    logic        tblock_done_i;
    logic [3:0]  tblock_done_id_i;
    logic        tblock_done_ready_o;
    logic        group_done_o;
    logic [3:0]  group_done_id_o;
    logic        group_done_ready_i;
`ifdef BGPU_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tblock_dispatcher dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .launch_valid_i        (launch_valid_i),
        .launch_ready_o        (launch_ready_o),
        .launch_pc_i           (launch_pc_i),
        .launch_dp_addr_i      (launch_dp_addr_i),
        .launch_num_tblocks_i  (launch_num_tblocks_i),
        .launch_tgroup_id_i    (launch_tgroup_id_i),
        .warp_free_i           (warp_free_i),
        .allocate_warp_o       (allocate_warp_o),
        .allocate_pc_o         (allocate_pc_o),
        .allocate_dp_addr_o    (allocate_dp_addr_o),
        .allocate_tblock_idx_o (allocate_tblock_idx_o),
        .allocate_tgroup_id_o  (allocate_tgroup_id_o),
        .tblock_done_i         (tblock_done_i),
        .tblock_done_id_i      (tblock_done_id_i),
        .tblock_done_ready_o   (tblock_done_ready_o),
        .group_done_o          (group_done_o),
        .group_done_id_o       (group_done_id_o),
        .group_done_ready_i    (group_done_ready_i)
`ifdef BGPU_DISPATCH_STALL_CNT_EN
        ,
        .stall_cycles_o        (stall_cycles_o)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a launch for one cycle; returns with DUT past the handshake edge.
    task automatic launch(input logic [4:0] num, input logic [3:0] id,
                          input logic [31:0] pc, input logic [31:0] dp);
        launch_valid_i       = 1'b1;
        launch_num_tblocks_i = num;
        launch_tgroup_id_i   = id;
        launch_pc_i          = pc;
        launch_dp_addr_i     = dp;
        step();
        launch_valid_i       = 1'b0;
        launch_num_tblocks_i = '0;
        launch_tgroup_id_i   = '0;
        launch_pc_i          = '0;
        launch_dp_addr_i     = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        launch_valid_i = 0; launch_pc_i = '0; launch_dp_addr_i = '0;
        launch_num_tblocks_i = '0; launch_tgroup_id_i = '0;
        warp_free_i = 0; tblock_done_i = 0; tblock_done_id_i = '0; group_done_ready_i = 0;
        #12;
        checks++; if (launch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_launch_ready got %b exp 1", launch_ready_o); end
        checks++;
        if ({allocate_warp_o, allocate_pc_o, allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tgroup_id_o,
             tblock_done_ready_o, group_done_o, group_done_id_o} !== '0) begin
            errors++; $display("FAIL reset_outputs_zero alloc=%b pc=%h done_rdy=%b gd=%b", allocate_warp_o,
                               allocate_pc_o, tblock_done_ready_o, group_done_o);
        end
`ifdef BGPU_DISPATCH_STALL_CNT_EN
        checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles_o); end
`endif
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_basic();
        warp_free_i = 1'b1;
        launch(5'd3, 4'd5, 32'h100, 32'h2000);
        checks++; if (launch_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_low got %b exp 0", launch_ready_o); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (allocate_warp_o !== 1'b1 || allocate_tblock_idx_o !== 4'(i) || allocate_pc_o !== 32'h100 ||
                allocate_dp_addr_o !== 32'h2000 || allocate_tgroup_id_o !== 4'd5) begin
                errors++; $display("FAIL basic_alloc%0d got v=%b idx=%0d pc=%h dp=%h id=%0d exp v=1 idx=%0d pc=100 dp=2000 id=5",
                                   i, allocate_warp_o, allocate_tblock_idx_o, allocate_pc_o, allocate_dp_addr_o,
                                   allocate_tgroup_id_o, i);
            end
            step();
        end
        checks++;
        if (allocate_warp_o !== 1'b0 || allocate_pc_o !== 32'h0 || tblock_done_ready_o !== 1'b1) begin
            errors++; $display("FAIL basic_wait_done got alloc=%b pc=%h done_rdy=%b exp 0 0 1",
                               allocate_warp_o, allocate_pc_o, tblock_done_ready_o);
        end
        warp_free_i = 1'b0;
        tblock_done_i = 1'b1; tblock_done_id_i = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) begin
                checks++; if (group_done_o !== 1'b0) begin errors++; $display("FAIL basic_early_group_done%0d got 1 exp 0", i); end
            end
        end
        tblock_done_i = 1'b0; tblock_done_id_i = '0;
        checks++;
        if (group_done_o !== 1'b1 || group_done_id_o !== 4'd5 || tblock_done_ready_o !== 1'b0) begin
            errors++; $display("FAIL basic_group_done got gd=%b id=%0d done_rdy=%b exp 1 5 0",
                               group_done_o, group_done_id_o, tblock_done_ready_o);
        end
        group_done_ready_i = 1'b1;
        step();
        group_done_ready_i = 1'b0;
        checks++;
        if (launch_ready_o !== 1'b1 || group_done_o !== 1'b0 || group_done_id_o !== 4'd0) begin
            errors++; $display("FAIL basic_back_idle got rdy=%b gd=%b id=%0d exp 1 0 0", launch_ready_o, group_done_o, group_done_id_o);
        end
    endtask

    task automatic test_stall();
        logic [5:0] free_pat;
        logic [5:0] exp_alloc;
        logic [3:0] exp_idx [6];
        int n_alloc;
        free_pat  = 6'b111001;  // bit i = warp_free in cycle i
        exp_alloc = 6'b111001;
        exp_idx   = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
        n_alloc   = 0;
        launch(5'd4, 4'd1, 32'h400, 32'h80);
        for (int i = 0; i < 6; i++) begin
            warp_free_i = free_pat[i];
            #1;
            if (allocate_warp_o === 1'b1) n_alloc++;
            checks++;
            if (allocate_warp_o !== exp_alloc[i] || (exp_alloc[i] && allocate_tblock_idx_o !== exp_idx[i])) begin
                errors++; $display("FAIL stall_cycle%0d got v=%b idx=%0d exp v=%b idx=%0d", i, allocate_warp_o,
                                   allocate_tblock_idx_o, exp_alloc[i], exp_idx[i]);
            end
            step();
        end
        warp_free_i = 1'b1;
        #1;
        checks++;
        if (allocate_warp_o !== 1'b0 || n_alloc != 4) begin
            errors++; $display("FAIL stall_total got allocs=%0d post_alloc=%b exp 4 0", n_alloc, allocate_warp_o);
        end
`ifdef BGPU_DISPATCH_STALL_CNT_EN
        checks++; if (stall_cycles_o !== 32'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", stall_cycles_o); end
`endif
        warp_free_i = 1'b0;
        tblock_done_i = 1'b1; tblock_done_id_i = 4'd1;
        for (int i = 0; i < 4; i++) step();
        tblock_done_i = 1'b0;
        checks++;
        if (group_done_o !== 1'b1 || group_done_id_o !== 4'd1) begin
            errors++; $display("FAIL stall_group_done got gd=%b id=%0d exp 1 1", group_done_o, group_done_id_o);
        end
        group_done_ready_i = 1'b1;
        step();
        group_done_ready_i = 1'b0;
    endtask

    task automatic test_zero();
        warp_free_i = 1'b1;
        launch(5'd0, 4'd2, 32'h500, 32'h0);
        checks++;
        if (group_done_o !== 1'b1 || group_done_id_o !== 4'd2 || allocate_warp_o !== 1'b0 || tblock_done_ready_o !== 1'b0) begin
            errors++; $display("FAIL zero_report got gd=%b id=%0d alloc=%b done_rdy=%b exp 1 2 0 0",
                               group_done_o, group_done_id_o, allocate_warp_o, tblock_done_ready_o);
        end
        warp_free_i = 1'b0;
        group_done_ready_i = 1'b1;
        step();
        group_done_ready_i = 1'b0;
        checks++; if (launch_ready_o !== 1'b1) begin errors++; $display("FAIL zero_idle got rdy=%b exp 1", launch_ready_o); end
    endtask

    task automatic test_coincident();
        warp_free_i = 1'b1;
        launch(5'd2, 4'd5, 32'h600, 32'h10);
        step();
        tblock_done_i = 1'b1; tblock_done_id_i = 4'd5;
        #1;
        checks++;
        if (allocate_warp_o !== 1'b1 || allocate_tblock_idx_o !== 4'd1 || tblock_done_ready_o !== 1'b1) begin
            errors++; $display("FAIL coinc_alloc1 got v=%b idx=%0d done_rdy=%b exp 1 1 1",
                               allocate_warp_o, allocate_tblock_idx_o, tblock_done_ready_o);
        end
        step();
        warp_free_i = 1'b0;
        tblock_done_id_i = 4'd7;
        checks++;
        if (allocate_warp_o !== 1'b0 || tblock_done_ready_o !== 1'b1 || group_done_o !== 1'b0) begin
            errors++; $display("FAIL coinc_wait got alloc=%b done_rdy=%b gd=%b exp 0 1 0",
                               allocate_warp_o, tblock_done_ready_o, group_done_o);
        end
        step();
        checks++;
        if (group_done_o !== 1'b0 || tblock_done_ready_o !== 1'b1) begin
            errors++; $display("FAIL coinc_drop got gd=%b done_rdy=%b exp 0 1", group_done_o, tblock_done_ready_o);
        end
        tblock_done_id_i = 4'd5;
        step();
        tblock_done_i = 1'b0; tblock_done_id_i = '0;
        checks++;
        if (group_done_o !== 1'b1 || group_done_id_o !== 4'd5) begin
            errors++; $display("FAIL coinc_group_done got gd=%b id=%0d exp 1 5", group_done_o, group_done_id_o);
        end
        group_done_ready_i = 1'b1;
        step();
        group_done_ready_i = 1'b0;
    endtask

    task automatic test_report_hold();
        warp_free_i = 1'b1;
        launch(5'd1, 4'd3, 32'h700, 32'h20);
        step();
        warp_free_i = 1'b0;
        tblock_done_i = 1'b1; tblock_done_id_i = 4'd3;
        step();
        tblock_done_i = 1'b0; tblock_done_id_i = '0;
        launch_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (group_done_o !== 1'b1 || group_done_id_o !== 4'd3 || launch_ready_o !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d got gd=%b id=%0d rdy=%b exp 1 3 0",
                                   i, group_done_o, group_done_id_o, launch_ready_o);
            end
            step();
        end
        launch_valid_i = 1'b0;
        group_done_ready_i = 1'b1;
        step();
        group_done_ready_i = 1'b0;
        checks++;
        if (launch_ready_o !== 1'b1 || group_done_o !== 1'b0) begin
            errors++; $display("FAIL hold_release got rdy=%b gd=%b exp 1 0", launch_ready_o, group_done_o);
        end
    endtask

    task automatic test_mid_reset();
        int gd_seen;
        gd_seen = 0;
        warp_free_i = 1'b1;
        launch(5'd4, 4'd6, 32'h800, 32'h30);
        step();
        warp_free_i = 1'b0;
        step();
        warp_free_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (launch_ready_o !== 1'b1 || allocate_warp_o !== 1'b0 || allocate_pc_o !== 32'h0 ||
            allocate_tgroup_id_o !== 4'd0 || allocate_tblock_idx_o !== 4'd0 || tblock_done_ready_o !== 1'b0 ||
            group_done_o !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got rdy=%b alloc=%b pc=%h id=%0d idx=%0d done_rdy=%b gd=%b",
                               launch_ready_o, allocate_warp_o, allocate_pc_o, allocate_tgroup_id_o,
                               allocate_tblock_idx_o, tblock_done_ready_o, group_done_o);
        end
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (group_done_o !== 1'b0 || allocate_warp_o !== 1'b0) gd_seen++;
            step();
        end
        checks++; if (gd_seen != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", gd_seen); end
        launch(5'd1, 4'd9, 32'h900, 32'h40);
        checks++;
        if (allocate_warp_o !== 1'b1 || allocate_tblock_idx_o !== 4'd0 || allocate_tgroup_id_o !== 4'd9) begin
            errors++; $display("FAIL midrst_relaunch got v=%b idx=%0d id=%0d exp 1 0 9",
                               allocate_warp_o, allocate_tblock_idx_o, allocate_tgroup_id_o);
        end
        warp_free_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_coincident();
        test_report_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
